// File: rtl/demux4_pkg.sv
// Shared constants and lane state type for the demux4_reg 1-to-4 registered demultiplexer.
package demux4_pkg;

  localparam int unsigned DEMUX4_LANES = 4;
  localparam int unsigned DEMUX4_SEL_W = 2;
  localparam int unsigned DEMUX4_CNT_W = 16;

  localparam logic [DEMUX4_SEL_W-1:0] LANE0 = 2'd0;
  localparam logic [DEMUX4_SEL_W-1:0] LANE1 = 2'd1;
  localparam logic [DEMUX4_SEL_W-1:0] LANE2 = 2'd2;
  localparam logic [DEMUX4_SEL_W-1:0] LANE3 = 2'd3;

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_t;

endpackage

// File: rtl/demux4_lane.sv
// One output lane of demux4_reg: single-entry holding register with valid/ready drain.
// Optional per-lane accept counter is built when DEMUX4_CNT_EN is defined.
module demux4_lane
  import demux4_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             can_accept,
  output logic [WIDTH-1:0] data,
  output logic             valid
`ifdef DEMUX4_CNT_EN
  ,
  output logic [DEMUX4_CNT_W-1:0] cnt
`endif
);

  lane_state_t state, state_nx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= LANE_EMPTY;
    else          state <= state_nx;
  end

  // A write in the same cycle as a drain keeps the lane full with the new word.
  always_comb begin
    state_nx = state;
    case (state)
      LANE_EMPTY: if (wr) state_nx = LANE_FULL;
      LANE_FULL:  if (!wr && rd_ready) state_nx = LANE_EMPTY;
    endcase
  end

  assign valid      = (state == LANE_FULL);
  assign can_accept = (state == LANE_EMPTY) | rd_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  data <= '0;
    else if (wr)   data <= wr_data;
  end

`ifdef DEMUX4_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (wr)  cnt <= cnt + DEMUX4_CNT_W'(1);
  end
`endif

endmodule

// File: rtl/demux4_reg.sv
// 32-bit 1-to-4 demultiplexer with per-lane registered valid/ready outputs.
// Define DEMUX4_CNT_EN to add 16-bit per-lane accept counters xfer_cnt0..3.
module demux4_reg
  import demux4_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = DEMUX4_LANES
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [DEMUX4_SEL_W-1:0] in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data0,
  output logic [WIDTH-1:0]        out_data1,
  output logic [WIDTH-1:0]        out_data2,
  output logic [WIDTH-1:0]        out_data3,
  output logic [LANES-1:0]        out_valid,
  input  logic [LANES-1:0]        out_ready
`ifdef DEMUX4_CNT_EN
  ,
  output logic [DEMUX4_CNT_W-1:0] xfer_cnt0,
  output logic [DEMUX4_CNT_W-1:0] xfer_cnt1,
  output logic [DEMUX4_CNT_W-1:0] xfer_cnt2,
  output logic [DEMUX4_CNT_W-1:0] xfer_cnt3
`endif
);

  logic [LANES-1:0] lane_wr;
  logic [LANES-1:0] lane_can;
  logic [LANES-1:0] lane_valid;
  logic [WIDTH-1:0] lane_data [LANES];
`ifdef DEMUX4_CNT_EN
  logic [DEMUX4_CNT_W-1:0] lane_cnt [LANES];
`endif

  // in_ready looks only at the selected lane, never at in_valid.
  assign in_ready = lane_can[in_sel];

  always_comb begin
    lane_wr = '0;
    if (in_valid && in_ready) lane_wr[in_sel] = 1'b1;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    demux4_lane #(.WIDTH(WIDTH)) u_lane (
      .clock      (clock),
      .reset_n    (reset_n),
      .wr         (lane_wr[i]),
      .wr_data    (in_data),
      .rd_ready   (out_ready[i]),
      .can_accept (lane_can[i]),
      .data       (lane_data[i]),
      .valid      (lane_valid[i])
`ifdef DEMUX4_CNT_EN
      ,
      .cnt        (lane_cnt[i])
`endif
    );
  end

  assign out_valid = lane_valid;
  assign out_data0 = lane_data[LANE0];
  assign out_data1 = lane_data[LANE1];
  assign out_data2 = lane_data[LANE2];
  assign out_data3 = lane_data[LANE3];

`ifdef DEMUX4_CNT_EN
  assign xfer_cnt0 = lane_cnt[LANE0];
  assign xfer_cnt1 = lane_cnt[LANE1];
  assign xfer_cnt2 = lane_cnt[LANE2];
  assign xfer_cnt3 = lane_cnt[LANE3];
`endif

endmodule
